commit_stage: RTL and testbench

//   Writeback stage directly downstream of the memory stage. Registers the two CMT_REQUIRE

---
 rtl/commit_stage_if.sv | 39 +++
 rtl/commit_stage.sv | 89 ++++++++
 tb/tb_commit_stage.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/commit_stage_if.sv
// Commit-stage lane bundle and the memory-stage/commit-stage interface.
// Carries lane capture, read ports and the committed writeback view.
package commit_pkg;
  localparam int REG_WIDTH = 32;
  localparam int NUM_REGS = 32;
  localparam int CMT_AW = $clog2(NUM_REGS);

  typedef struct packed {
    logic [REG_WIDTH-1:0] result;
    logic write_reg_need;
    logic [CMT_AW-1:0] write_reg_addr;
  } cmt_require_t;
endpackage

interface commit_if #(
  parameter int AW = commit_pkg::CMT_AW,
  parameter int CNT_WIDTH = 32
);
  import commit_pkg::*;

  cmt_require_t [1:0] cmt_require;
  logic stall_from_memory;
  logic [3:0][AW-1:0] rd_addr;
  logic [3:0][REG_WIDTH-1:0] rd_data;
  logic [1:0] wb_need;
  logic [1:0][AW-1:0] wb_addr;
  logic [1:0][REG_WIDTH-1:0] wb_data;
  logic [CNT_WIDTH-1:0] wb_count;

  modport master (
    output cmt_require, stall_from_memory, rd_addr,
    input rd_data, wb_need, wb_addr, wb_data, wb_count
  );

  modport slave (
    input cmt_require, stall_from_memory, rd_addr,
    output rd_data, wb_need, wb_addr, wb_data, wb_count
  );
endinterface

// File: rtl/commit_stage.sv
// Writeback stage: one commit register for two lanes feeding a
// 2-write/4-read register file with read bypass from the commit register.
module commit_stage
  import commit_pkg::*;
#(
  parameter int NUM_REGS = commit_pkg::NUM_REGS,
  parameter int CNT_WIDTH = 32
) (
  input logic clk,
  input logic rst_n,
  commit_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);

  cmt_require_t [1:0] cmt_q;
  logic [REG_WIDTH-1:0] regs [NUM_REGS];
  logic [1:0] wr_en;
  logic [1:0] inc;

  // Bubble on stall: the memory stage re-presents the same lanes later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmt_q <= '0;
    end else if (bus.stall_from_memory) begin
      cmt_q <= '0;
    end else begin
      cmt_q <= bus.cmt_require;
    end
  end

  always_comb begin
    wr_en = '0;
    for (int i = 0; i < 2; i++) begin
      wr_en[i] = cmt_q[i].write_reg_need &&
                 (cmt_q[i].write_reg_addr != '0);
    end
  end

  assign inc = {1'b0, wr_en[0]} + {1'b0, wr_en[1]};

  // Lane 1 is applied last so it wins on a shared destination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wr_en[i]) begin
          regs[cmt_q[i].write_reg_addr] <= cmt_q[i].result;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wb_count <= '0;
    end else begin
      bus.wb_count <= bus.wb_count + CNT_WIDTH'(inc);
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      bus.wb_need[i] = cmt_q[i].write_reg_need;
      bus.wb_addr[i] = cmt_q[i].write_reg_addr;
      bus.wb_data[i] = cmt_q[i].result;
    end
  end

  // Later assignments take priority: r0, then lane 1, then lane 0.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      bus.rd_data[p] = regs[bus.rd_addr[p]];
      if (cmt_q[0].write_reg_need &&
          cmt_q[0].write_reg_addr == bus.rd_addr[p]) begin
        bus.rd_data[p] = cmt_q[0].result;
      end
      if (cmt_q[1].write_reg_need &&
          cmt_q[1].write_reg_addr == bus.rd_addr[p]) begin
        bus.rd_data[p] = cmt_q[1].result;
      end
      if (bus.rd_addr[p] == '0) begin
        bus.rd_data[p] = '0;
      end
    end
  end
endmodule

// File: tb/tb_commit_stage.sv
// Bench for commit_stage: scoreboard of expected commits plus a
// reference register file and write counter.
module tb_commit_stage;
  import commit_pkg::*;

  typedef struct {
    logic [1:0] need;
    logic [1:0][4:0] addr;
    logic [1:0][31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int failures = 0;

  exp_t sb[$];
  exp_t last;
  logic [31:0] mreg [32];
  int unsigned mcnt;

  commit_if bus ();
  commit_if #(.CNT_WIDTH(4)) bus4 ();

  commit_stage dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  commit_stage #(.CNT_WIDTH(4)) dut4 (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus4)
  );

  always #5 clk = ~clk;

  function automatic cmt_require_t mk(
    input logic need, input logic [4:0] a, input logic [31:0] d);
    cmt_require_t c;
    c.result = d;
    c.write_reg_need = need;
    c.write_reg_addr = a;
    return c;
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (last.need[1] && last.addr[1] == a) return last.data[1];
    if (last.need[0] && last.addr[0] == a) return last.data[0];
    return mreg[a];
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < 32; r++) mreg[r] = 32'd0;
    mcnt = 0;
    last = '{default: '0};
    sb.delete();
  endfunction

  // Drive one cycle of lanes, push the expected commit, step the model.
  task automatic drive(input logic stall,
                       input cmt_require_t l0, input cmt_require_t l1);
    exp_t e;
    bus.stall_from_memory = stall;
    bus.cmt_require[0] = l0;
    bus.cmt_require[1] = l1;
    e = '{default: '0};
    if (!stall) begin
      e.need = {l1.write_reg_need, l0.write_reg_need};
      e.addr[0] = l0.write_reg_addr;
      e.addr[1] = l1.write_reg_addr;
      e.data[0] = l0.result;
      e.data[1] = l1.result;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (last.need[i] && last.addr[i] != 5'd0) begin
        mreg[last.addr[i]] = last.data[i];
        mcnt++;
      end
    end
    last = e;
  endtask

  task automatic idle();
    drive(1'b0, mk(0, 0, 0), mk(0, 0, 0));
  endtask

  task automatic test_reset();
    bus.rd_addr = '{5'd1, 5'd2, 5'd3, 5'd4};
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.wb_need !== 2'b00) begin
      failures++;
      $display("FAIL reset_wb_need got=%b want=00", bus.wb_need);
    end
    checks++;
    if (bus.wb_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_wb_count got=%0d want=0", bus.wb_count);
    end
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (bus.rd_data[p] !== 32'd0) begin
        failures++;
        $display("FAIL reset_rd%0d got=%h want=0", p, bus.rd_data[p]);
      end
    end
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lane0();
    exp_t e;
    bus.rd_addr[0] = 5'd5;
    drive(1'b0, mk(1, 5, 32'hDEADBEEF), mk(0, 0, 0));
    e = sb.pop_front();
    checks++;
    if ({bus.wb_need, bus.wb_addr, bus.wb_data} !==
        {e.need, e.addr, e.data}) begin
      failures++;
      $display("FAIL lane0_wb got=%b/%h want=%b/%h",
               bus.wb_need, bus.wb_data[0], e.need, e.data[0]);
    end
    checks++;
    if (bus.rd_data[0] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL lane0_bypass got=%h want=deadbeef", bus.rd_data[0]);
    end
    idle();
    void'(sb.pop_front());
    checks++;
    if (bus.rd_data[0] !== mread(5'd5)) begin
      failures++;
      $display("FAIL lane0_array got=%h want=%h",
               bus.rd_data[0], mread(5'd5));
    end
    checks++;
    if (bus.wb_count !== 32'(mcnt) || mcnt != 1) begin
      failures++;
      $display("FAIL lane0_count got=%0d want=1", bus.wb_count);
    end
  endtask

  task automatic test_same_addr();
    exp_t e;
    int unsigned c0 = mcnt;
    bus.rd_addr[1] = 5'd7;
    drive(1'b0, mk(1, 7, 32'd11), mk(1, 7, 32'd22));
    e = sb.pop_front();
    checks++;
    if ({bus.wb_need, bus.wb_addr, bus.wb_data} !==
        {e.need, e.addr, e.data}) begin
      failures++;
      $display("FAIL same_wb got=%b want=%b", bus.wb_need, e.need);
    end
    checks++;
    if (bus.rd_data[1] !== 32'd22) begin
      failures++;
      $display("FAIL same_bypass got=%0d want=22", bus.rd_data[1]);
    end
    idle();
    void'(sb.pop_front());
    checks++;
    if (bus.rd_data[1] !== 32'd22) begin
      failures++;
      $display("FAIL same_array got=%0d want=22", bus.rd_data[1]);
    end
    checks++;
    if (bus.wb_count !== 32'(c0 + 2)) begin
      failures++;
      $display("FAIL same_count got=%0d want=%0d", bus.wb_count, c0 + 2);
    end
  endtask

  task automatic test_addr0();
    exp_t e;
    int unsigned c0 = mcnt;
    bus.rd_addr[2] = 5'd0;
    drive(1'b0, mk(0, 0, 0), mk(1, 0, 32'hFFFF));
    e = sb.pop_front();
    checks++;
    if ({bus.wb_need, bus.wb_addr, bus.wb_data} !==
        {e.need, e.addr, e.data}) begin
      failures++;
      $display("FAIL addr0_wb got=%b want=%b", bus.wb_need, e.need);
    end
    checks++;
    if (bus.rd_data[2] !== 32'd0) begin
      failures++;
      $display("FAIL addr0_bypass got=%h want=0", bus.rd_data[2]);
    end
    idle();
    void'(sb.pop_front());
    checks++;
    if (bus.rd_data[2] !== 32'd0 || bus.wb_count !== 32'(c0)) begin
      failures++;
      $display("FAIL addr0_array rd=%h cnt=%0d want 0/%0d",
               bus.rd_data[2], bus.wb_count, c0);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    int unsigned c0 = mcnt;
    bus.rd_addr[3] = 5'd9;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, mk(1, 9, 32'd3), mk(0, 0, 0));
      e = sb.pop_front();
      checks++;
      if (bus.wb_need !== e.need || e.need != 2'b00) begin
        failures++;
        $display("FAIL stall_need%0d got=%b want=00", k, bus.wb_need);
      end
    end
    drive(1'b0, mk(1, 9, 32'd3), mk(0, 0, 0));
    e = sb.pop_front();
    checks++;
    if ({bus.wb_need, bus.wb_addr, bus.wb_data} !==
        {e.need, e.addr, e.data}) begin
      failures++;
      $display("FAIL stall_release got=%b want=%b", bus.wb_need, e.need);
    end
    idle();
    void'(sb.pop_front());
    idle();
    void'(sb.pop_front());
    checks++;
    if (bus.rd_data[3] !== 32'd3) begin
      failures++;
      $display("FAIL stall_r9 got=%0d want=3", bus.rd_data[3]);
    end
    checks++;
    if (bus.wb_count !== 32'(c0 + 1)) begin
      failures++;
      $display("FAIL stall_count got=%0d want=%0d", bus.wb_count, c0 + 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] a;
    logic [31:0] d0, d1;
    for (int k = 0; k < 8; k++) begin
      a = 5'($urandom_range(1, 31));
      d0 = $urandom;
      d1 = $urandom;
      bus.rd_addr = '{a, 5'($urandom_range(0, 31)), 5'd7, 5'(a + 5'd1)};
      drive(1'b0, mk(1, a, d0), mk(k[0], 5'(a + 5'd1), d1));
      void'(sb.pop_front());
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (bus.rd_data[p] !== mread(bus.rd_addr[p])) begin
          failures++;
          $display("FAIL b2b_rd%0d_%0d got=%h want=%h", k, p,
                   bus.rd_data[p], mread(bus.rd_addr[p]));
        end
      end
      checks++;
      if (bus.wb_count !== 32'(mcnt)) begin
        failures++;
        $display("FAIL b2b_count%0d got=%0d want=%0d",
                 k, bus.wb_count, mcnt);
      end
    end
    idle();
    void'(sb.pop_front());
  endtask

  task automatic test_wrap();
    int unsigned n = 0;
    for (int k = 0; k < 16; k++) begin
      bus4.cmt_require[0] = mk(1, 5'd1, 32'(k));
      @(posedge clk);
      #1;
      if (k > 0) n++;
    end
    bus4.cmt_require[0] = mk(0, 0, 0);
    checks++;
    if (bus4.wb_count !== 4'(n) || n != 15) begin
      failures++;
      $display("FAIL wrap_pre got=%0d want=15", bus4.wb_count);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus4.wb_count !== 4'd0) begin
      failures++;
      $display("FAIL wrap got=%0d want=0", bus4.wb_count);
    end
  endtask

  task automatic test_async_reset();
    bus.rd_addr = '{5'd5, 5'd7, 5'd9, 5'd12};
    drive(1'b0, mk(1, 12, 32'hA5A5), mk(0, 0, 0));
    void'(sb.pop_front());
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.wb_need !== 2'b00 || bus.wb_count !== 32'd0) begin
      failures++;
      $display("FAIL mid_reset need=%b cnt=%0d want 00/0",
               bus.wb_need, bus.wb_count);
    end
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (bus.rd_data[p] !== 32'd0) begin
        failures++;
        $display("FAIL mid_reset_rd%0d got=%h want=0", p, bus.rd_data[p]);
      end
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, mk(1, 12, 32'h77), mk(0, 0, 0));
    void'(sb.pop_front());
    checks++;
    if (bus.rd_data[0] !== 32'h77 || bus.wb_need !== 2'b01) begin
      failures++;
      $display("FAIL post_reset rd=%h need=%b want 77/01",
               bus.rd_data[0], bus.wb_need);
    end
  endtask

  initial begin
    bus.cmt_require = '0;
    bus.stall_from_memory = 1'b0;
    bus.rd_addr = '0;
    bus4.cmt_require = '0;
    bus4.stall_from_memory = 1'b0;
    bus4.rd_addr = '0;
    model_clear();
    test_reset();
    test_lane0();
    test_same_addr();
    test_addr0();
    test_stall();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
